// File: rtl/mef_nivel_tanque.sv
// Level-sensor front end for the irrigation tank.
// Synchronises and debounces the three float switches, validates the thermometer
// pattern, and publishes the 2-bit level code {Nv1,Nv0} with valid, update-pulse
// and fault flags for the downstream fertiliser/cleaning FSM.
module mef_nivel_tanque #(
  parameter int DEB_CYCLES   = 4,
  parameter int FAULT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  output logic Nv1,
  output logic Nv0,
  output logic Valido,
  output logic Nv_upd,
  output logic Falha
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int FW = $clog2(FAULT_CYCLES + 1);

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SUSPECT = 2'b01,
    FAULT   = 2'b10
  } state_t;

  logic [2:0]    s_meta;
  logic [2:0]    s_sync;
  logic [2:0]    deb;
  logic [CW-1:0] cnt [3];

  state_t        state;
  logic [FW-1:0] fcnt;
  logic [1:0]    nv_q;
  logic [1:0]    nv_last;
  logic          valido_q;
  logic          falha_q;
  logic          upd_q;

  logic          legal;
  logic [1:0]    code;

  // Two-flop synchroniser for the asynchronous float switches.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (reset) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= {S2, S1, S0};
      s_sync <= s_meta;
    end
  end

  // Per-bit debounce: a bit is accepted only after it differs from the
  // debounced value for DEB_CYCLES consecutive synchronised cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      // NOTE: this counter array is three small registers, not a RAM, so it is
      // cleared like any other flop; a real memory would be left unreset.
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s_sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          deb[i] <= s_sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Thermometer decode of the debounced pattern into the level code.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    legal = 1'b1;
    code  = 2'b00;
    unique case (deb)
      3'b000:  code = 2'b00;
      3'b001:  code = 2'b01;
      3'b011:  code = 2'b10;
      3'b111:  code = 2'b11;
      default: legal = 1'b0;
    endcase
  end

  // Validation FSM with registered outputs; the code only ever takes legal values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= NORMAL;
      fcnt     <= '0;
      nv_q     <= 2'b00;
      nv_last  <= 2'b00;
      valido_q <= 1'b0;
      falha_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      nv_last <= nv_q;
      upd_q   <= (nv_q != nv_last);
      case (state)
        NORMAL: begin
          if (legal) begin
            nv_q     <= code;
            valido_q <= 1'b1;
            fcnt     <= '0;
          end else begin
            state <= SUSPECT;
            fcnt  <= FW'(1);
          end
        end
        SUSPECT: begin
          if (legal) begin
            state    <= NORMAL;
            nv_q     <= code;
            valido_q <= 1'b1;
            fcnt     <= '0;
          end else if (fcnt >= FW'(FAULT_CYCLES - 1)) begin
            state    <= FAULT;
            falha_q  <= 1'b1;
            valido_q <= 1'b0;
            fcnt     <= '0;
          end else if (fcnt != '1) begin
            fcnt <= fcnt + FW'(1);
          end
        end
        FAULT: begin
          valido_q <= 1'b0;
          falha_q  <= 1'b1;
          if (!legal) begin
            fcnt <= '0;
          end else if (fcnt >= FW'(FAULT_CYCLES - 1)) begin
            state    <= NORMAL;
            falha_q  <= 1'b0;
            valido_q <= 1'b1;
            nv_q     <= code;
            fcnt     <= '0;
          end else if (fcnt != '1) begin
            fcnt <= fcnt + FW'(1);
          end
        end
        default: begin
          state <= NORMAL;
          fcnt  <= '0;
        end
      endcase
    end
  end

  assign Nv1    = nv_q[1];
  assign Nv0    = nv_q[0];
  assign Valido = valido_q;
  assign Nv_upd = upd_q;
  assign Falha  = falha_q;

endmodule
